// File: rtl/pico_pkg.sv
// Shared definitions for the pico_core multi-cycle processor: opcodes,
// instruction field positions, FSM states and ALU operation encoding.
package pico_pkg;

    localparam int OPC_LSB = 12;
    localparam int FA_LSB  = 8;
    localparam int FB_LSB  = 4;
    localparam int FC_LSB  = 0;
    localparam int IND_BIT = 3;

    localparam logic [3:0] OP_MOV  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h5;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_OUT  = 4'h8;
    localparam logic [3:0] OP_STOP = 4'hF;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_FETCH,
        ST_FETCH_W,
        ST_DECODE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RD_IND,
        ST_EXEC,
        ST_WRITE,
        ST_IN_WAIT,
        ST_OUT_WAIT,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        FLD_A,
        FLD_B,
        FLD_C
    } field_t;

    // What the value coming back from an operand read is used for
    typedef enum logic [1:0] {
        PH_SRC,
        PH_DEST,
        PH_BRANCH
    } phase_t;

    typedef enum logic [2:0] {
        ALU_MOV,
        ALU_ADD,
        ALU_SUB,
        ALU_MUL,
        ALU_CMP
    } alu_op_t;

    function automatic alu_op_t alu_op_of(input logic [3:0] opc);
        case (opc)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_MUL:  return ALU_MUL;
            OP_BEQ:  return ALU_CMP;
            default: return ALU_MOV;
        endcase
    endfunction

    function automatic logic two_sources(input logic [3:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_MUL) || (opc == OP_BEQ);
    endfunction

    // BEQ and OUT read operand A first; arithmetic and MOV start at B
    function automatic field_t src_field(input logic [3:0] opc, input logic second);
        if (opc == OP_BEQ) begin
            return second ? FLD_B : FLD_A;
        end
        if (opc == OP_OUT) begin
            return FLD_A;
        end
        return second ? FLD_C : FLD_B;
    endfunction

endpackage

// File: rtl/pico_alu.sv
// Combinational datapath for pico_core: move, wrapping add/sub/mul and an
// equality flag used by BEQ.
module pico_alu
    import pico_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  alu_op_t               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  eq
);

    always_comb begin
        y = a;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_MUL: y = a * b;
            default: y = a;
        endcase
    end

    assign eq = (a == b);

endmodule

// File: rtl/pico_core.sv
// Multi-cycle memory-to-memory processor with a synchronous memory port,
// ready/valid input and output channels, and direct/indirect operands.
module pico_core
    import pico_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int PC_RESET   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_in,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted
);

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(PC_RESET);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

    state_t                state;
    phase_t                phase;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] src_x;
    logic [DATA_WIDTH-1:0] src_y;
    logic [DATA_WIDTH-1:0] result;
    logic [ADDR_WIDTH-1:0] dest_addr;
    logic                  src_second;
    logic                  ind_pending;

    logic [3:0]            opcode;
    logic [3:0]            fld_a;
    logic [3:0]            first_nib;
    logic [3:0]            second_nib;
    logic [ADDR_WIDTH-1:0] mem_ptr;
    logic [DATA_WIDTH-1:0] alu_y;
    logic                  alu_eq;
    alu_op_t               alu_op;

    function automatic logic [3:0] field_bits(input logic [15:0] word, input field_t f);
        case (f)
            FLD_A:   return word[FA_LSB +: 4];
            FLD_B:   return word[FB_LSB +: 4];
            default: return word[FC_LSB +: 4];
        endcase
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] field_addr(input logic [3:0] nib);
        return ADDR_WIDTH'(nib[2:0]);
    endfunction

    assign opcode     = ir[OPC_LSB +: 4];
    assign fld_a      = ir[FA_LSB +: 4];
    assign first_nib  = field_bits(ir[15:0], src_field(opcode, 1'b0));
    assign second_nib = field_bits(ir[15:0], src_field(opcode, 1'b1));
    assign mem_ptr    = mem_in[ADDR_WIDTH-1:0];
    assign alu_op     = alu_op_of(opcode);

    pico_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .op(alu_op),
        .a (src_x),
        .b (src_y),
        .y (alu_y),
        .eq(alu_eq)
    );

    // Outputs are registered: each transition sets up the port values the
    // next state needs, so memory sees the address during that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RESET;
            phase       <= PH_SRC;
            pc          <= PC_INIT;
            ir          <= '0;
            src_x       <= '0;
            src_y       <= '0;
            result      <= '0;
            dest_addr   <= '0;
            src_second  <= 1'b0;
            ind_pending <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_data    <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    mem_addr <= pc;
                    state    <= ST_FETCH;
                end
                ST_FETCH: begin
                    pc    <= pc + ONE;
                    state <= ST_FETCH_W;
                end
                ST_FETCH_W: begin
                    ir    <= mem_in;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    case (opcode)
                        OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_BEQ, OP_OUT: begin
                            phase       <= PH_SRC;
                            src_second  <= 1'b0;
                            mem_addr    <= field_addr(first_nib);
                            ind_pending <= first_nib[IND_BIT];
                            state       <= ST_RD_ADDR;
                        end
                        OP_IN: begin
                            if (fld_a[IND_BIT]) begin
                                phase       <= PH_DEST;
                                mem_addr    <= field_addr(fld_a);
                                ind_pending <= 1'b0;
                                state       <= ST_RD_ADDR;
                            end else begin
                                dest_addr <= field_addr(fld_a);
                                in_ready  <= 1'b1;
                                state     <= ST_IN_WAIT;
                            end
                        end
                        default: begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end
                    endcase
                end
                ST_RD_ADDR: begin
                    state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (ind_pending) begin
                        mem_addr    <= mem_ptr;
                        ind_pending <= 1'b0;
                        state       <= ST_RD_IND;
                    end else begin
                        case (phase)
                            PH_SRC: begin
                                if (!src_second) begin
                                    src_x <= mem_in;
                                    if (two_sources(opcode)) begin
                                        src_second  <= 1'b1;
                                        mem_addr    <= field_addr(second_nib);
                                        ind_pending <= second_nib[IND_BIT];
                                        state       <= ST_RD_ADDR;
                                    end else begin
                                        state <= ST_EXEC;
                                    end
                                end else begin
                                    src_y <= mem_in;
                                    state <= ST_EXEC;
                                end
                            end
                            // An indirect destination's pointer is the write address
                            PH_DEST: begin
                                dest_addr <= mem_ptr;
                                if (opcode == OP_IN) begin
                                    in_ready <= 1'b1;
                                    state    <= ST_IN_WAIT;
                                end else begin
                                    mem_we   <= 1'b1;
                                    mem_addr <= mem_ptr;
                                    mem_data <= result;
                                    state    <= ST_WRITE;
                                end
                            end
                            default: begin
                                pc       <= mem_ptr;
                                mem_addr <= mem_ptr;
                                state    <= ST_FETCH;
                            end
                        endcase
                    end
                end
                ST_RD_IND: begin
                    state <= ST_RD_DATA;
                end
                ST_EXEC: begin
                    result <= alu_y;
                    case (opcode)
                        OP_BEQ: begin
                            if (alu_eq) begin
                                phase       <= PH_BRANCH;
                                mem_addr    <= pc;
                                ind_pending <= 1'b0;
                                state       <= ST_RD_ADDR;
                            end else begin
                                pc       <= pc + ONE;
                                mem_addr <= pc + ONE;
                                state    <= ST_FETCH;
                            end
                        end
                        OP_OUT: begin
                            out_valid <= 1'b1;
                            out_data  <= src_x;
                            state     <= ST_OUT_WAIT;
                        end
                        default: begin
                            if (fld_a[IND_BIT]) begin
                                phase       <= PH_DEST;
                                mem_addr    <= field_addr(fld_a);
                                ind_pending <= 1'b0;
                                state       <= ST_RD_ADDR;
                            end else begin
                                dest_addr <= field_addr(fld_a);
                                mem_we    <= 1'b1;
                                mem_addr  <= field_addr(fld_a);
                                mem_data  <= alu_y;
                                state     <= ST_WRITE;
                            end
                        end
                    endcase
                end
                ST_WRITE: begin
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                    state    <= ST_FETCH;
                end
                ST_IN_WAIT: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        mem_we   <= 1'b1;
                        mem_addr <= dest_addr;
                        mem_data <= in_data;
                        state    <= ST_WRITE;
                    end
                end
                ST_OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        mem_addr  <= pc;
                        state     <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_RESET;
                end
            endcase
        end
    end

endmodule
